// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction-fetch stage of the 5-stage pipeline.
//
// This unit owns the PC and drives a word address to a synchronous instruction ROM. The ROM
// registers its read on the falling edge. The returned word is captured into the IF/ID
// pipeline register on the next rising edge. Each posedge applies redirect, stall and
// out-of-range handling, with redirect taking the highest priority.
//
// Parameters:
//   RESET_PC    byte address fetched first after reset (bits [1:0] must be 0)
//   ADDR_WIDTH  ROM depth is 2**ADDR_WIDTH words; must match the ROM instance
//
// Ports:
//   clk           single clock, all state updates on posedge
//   rst           asynchronous active-high reset
//   stall         hold PC and IF/ID
//   redirect      branch/jump taken in EX this cycle
//   redirect_pc   byte target of the redirect; bits [1:0] are ignored
//   rom_addr      word address to the ROM, {2'b00, pc[31:2]}
//   rom_dout      ROM data for rom_addr (0 when out of range)
//   if_id_pc      PC of the captured instruction
//   if_id_pc4     if_id_pc + 4
//   if_id_inst    captured instruction, 32'h0 for a bubble
//   if_id_valid   1 = real instruction, 0 = bubble
//   fetch_err     sticky flag: PC left the ROM range; cleared by redirect or reset
//   perf_fetched  valid instructions delivered
//   perf_stalls   stall cycles (stall=1, redirect=0)
//
// Build option:
//   IF_PERF_CNT_EN  when defined, builds the two 32-bit wrapping performance counters.
//                   When undefined, perf_fetched and perf_stalls are tied to 32'h0.

module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_dout,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic        fetch_err,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        err_q, err_d;
  logic        in_range;
  logic        load_valid;

  // Any PC bit above the ROM's byte-address span means the fetch is outside the ROM.
  assign in_range = ((pc_q >> (ADDR_WIDTH + 2)) == 32'd0);

  assign rom_addr = {2'b00, pc_q[31:2]};

  // The IF/ID register takes a real instruction only on the lowest-priority path.
  assign load_valid = !redirect && !stall && in_range;

  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    err_d      = err_q;

    if (redirect) begin
      // Redirect overrides stall and discards any held IF/ID content.
      pc_d       = {redirect_pc[31:2], 2'b00};
      id_pc_d    = 32'h0;
      id_pc4_d   = 32'h0;
      id_inst_d  = 32'h0;
      id_valid_d = 1'b0;
      err_d      = 1'b0;
    end else if (stall) begin
      // Hold everything.
    end else if (!in_range) begin
      // Park the PC and keep emitting bubbles until redirected.
      id_pc_d    = 32'h0;
      id_pc4_d   = 32'h0;
      id_inst_d  = 32'h0;
      id_valid_d = 1'b0;
      err_d      = 1'b1;
    end else begin
      id_pc_d    = pc_q;
      id_pc4_d   = pc_q + 32'd4;
      id_inst_d  = rom_dout;
      id_valid_d = 1'b1;
      pc_d       = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= {RESET_PC[31:2], 2'b00};
      id_pc_q    <= 32'h0;
      id_pc4_q   <= 32'h0;
      id_inst_q  <= 32'h0;
      id_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
      err_q      <= err_d;
    end
  end

  assign if_id_pc    = id_pc_q;
  assign if_id_pc4   = id_pc4_q;
  assign if_id_inst  = id_inst_q;
  assign if_id_valid = id_valid_q;
  assign fetch_err   = err_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetched_q;
  logic [31:0] stalls_q;

  // Both counters wrap naturally at 2**32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= 32'h0;
      stalls_q  <= 32'h0;
    end else begin
      if (load_valid) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if (stall && !redirect) begin
        stalls_q <= stalls_q + 32'd1;
      end
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stalls  = stalls_q;
`else
  logic unused_perf;
  assign unused_perf  = load_valid;
  assign perf_fetched = 32'h0;
  assign perf_stalls  = 32'h0;
`endif

endmodule
